// File: rtl/banner_scan_ctrl_if.sv
// Control, char-write and display-side signals of the banner scanner.
// The slave modport is the scanner; the master modport is its driver.
interface banner_scan_ctrl_if #(
    parameter int MAX_CHARS = 16
) ();
    localparam int AW = $clog2(MAX_CHARS);

    logic          start;
    logic          stop;
    logic          loop_en;
    logic [AW:0]   msg_len;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [4:0]    wr_char;
    logic [4:0]    lines;
    logic          col_strobe;
    logic          busy;
    logic          done;

    modport master (
        output start, stop, loop_en, msg_len, wr_en, wr_addr, wr_char,
        input  lines, col_strobe, busy, done
    );

    modport slave (
        input  start, stop, loop_en, msg_len, wr_en, wr_addr, wr_char,
        output lines, col_strobe, busy, done
    );
endinterface

// File: rtl/banner_scan_ctrl.sv
// 5-line dot-matrix banner sequencer: scans buffered chars out column by
// column (4 glyph columns + 1 blank gap), each held for COL_TICKS clocks.
module banner_scan_ctrl #(
    parameter int MAX_CHARS = 16,
    parameter int COL_TICKS = 4,
    parameter int CHAR_W    = 4
) (
    input logic clk,
    input logic rst_n,
    banner_scan_ctrl_if.slave bus
);
    localparam int AW = $clog2(MAX_CHARS);
    localparam int TW = (COL_TICKS > 1) ? $clog2(COL_TICKS) : 1;
    localparam logic [TW-1:0] LAST_TICK = TW'(COL_TICKS - 1);
    localparam logic [1:0]    LAST_COL  = 2'(CHAR_W - 1);
    localparam logic [AW:0]   CAP       = (AW+1)'(MAX_CHARS);

    typedef enum logic [1:0] {IDLE, SCAN, GAP} state_t;

    state_t        state, state_n;
    logic [TW-1:0] tick, tick_n;
    logic [1:0]    col, col_n;
    logic [AW-1:0] idx, idx_n;
    logic [AW:0]   len, len_n;
    logic          strobe_n, done_n;
    logic [4:0]    cbuf [MAX_CHARS];

    // Glyph columns packed col0 in [19:15] .. col3 in [4:0], MSB = top line.
    function automatic logic [4:0] font(input logic [4:0] code, input logic [1:0] c);
        logic [19:0] g;
        g = '0;
        case (code)
            5'd1:  g = 20'b01111_10100_10100_01111;
            5'd2:  g = 20'b11111_10101_10101_01010;
            5'd3:  g = 20'b01110_10001_10001_10001;
            5'd4:  g = 20'b11111_10001_10001_01110;
            5'd5:  g = 20'b11111_10101_10101_10001;
            5'd6:  g = 20'b11111_10100_10100_10000;
            5'd7:  g = 20'b01110_10001_10101_10111;
            5'd8:  g = 20'b11111_00100_00100_11111;
            5'd9:  g = 20'b00000_10001_11111_10001;
            5'd10: g = 20'b00010_00001_00001_11110;
            5'd11: g = 20'b11111_00100_01010_10001;
            5'd12: g = 20'b11111_00001_00001_00001;
            5'd13: g = 20'b11111_01000_01000_11111;
            5'd14: g = 20'b11111_01000_00100_11111;
            5'd15: g = 20'b01110_10001_10001_01110;
            5'd16: g = 20'b11111_10100_10100_01000;
            5'd17: g = 20'b01110_10001_10011_01111;
            5'd18: g = 20'b11111_10100_10110_01001;
            5'd19: g = 20'b11101_10101_10101_10111;
            5'd20: g = 20'b10000_11111_10000_10000;
            5'd21: g = 20'b11110_00001_00001_11110;
            5'd22: g = 20'b11100_00011_00011_11100;
            5'd23: g = 20'b11111_00010_00010_11111;
            5'd24: g = 20'b11011_00100_00100_11011;
            5'd25: g = 20'b11000_00111_00111_11000;
            5'd26: g = 20'b10011_10101_11001_10001;
            default: g = '0;
        endcase
        case (c)
            2'd0:    font = g[19:15];
            2'd1:    font = g[14:10];
            2'd2:    font = g[9:5];
            default: font = g[4:0];
        endcase
    endfunction

    always_comb begin
        state_n  = state;
        tick_n   = tick;
        col_n    = col;
        idx_n    = idx;
        len_n    = len;
        strobe_n = 1'b0;
        done_n   = 1'b0;
        case (state)
            IDLE: if (bus.start && bus.msg_len != '0) begin
                state_n  = SCAN;
                tick_n   = '0;
                col_n    = '0;
                idx_n    = '0;
                len_n    = (bus.msg_len > CAP) ? CAP : bus.msg_len;
                strobe_n = 1'b1;
            end
            SCAN: if (tick == LAST_TICK) begin
                tick_n   = '0;
                strobe_n = 1'b1;
                if (col == LAST_COL) state_n = GAP;
                else                 col_n   = col + 2'd1;
            end else begin
                tick_n = tick + TW'(1);
            end
            GAP: if (tick == LAST_TICK) begin
                tick_n = '0;
                col_n  = '0;
                if ({1'b0, idx} + (AW+1)'(1) < len) begin
                    idx_n    = idx + AW'(1);
                    state_n  = SCAN;
                    strobe_n = 1'b1;
                end else if (bus.loop_en) begin
                    idx_n    = '0;
                    state_n  = SCAN;
                    strobe_n = 1'b1;
                end else begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end else begin
                tick_n = tick + TW'(1);
            end
            default: state_n = IDLE;
        endcase
        // Abort overrides everything, including a same-cycle start.
        if (bus.stop) begin
            state_n  = IDLE;
            tick_n   = '0;
            col_n    = '0;
            idx_n    = '0;
            strobe_n = 1'b0;
            done_n   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            tick           <= '0;
            col            <= '0;
            idx            <= '0;
            len            <= '0;
            bus.lines      <= '0;
            bus.col_strobe <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            for (int i = 0; i < MAX_CHARS; i++) cbuf[i] <= '0;
        end else begin
            state          <= state_n;
            tick           <= tick_n;
            col            <= col_n;
            idx            <= idx_n;
            len            <= len_n;
            // Lines read the pre-write buffer, so a write shows up one cycle later.
            bus.lines      <= (state_n == SCAN) ? font(cbuf[idx_n], col_n) : 5'd0;
            bus.col_strobe <= strobe_n;
            bus.busy       <= (state_n != IDLE);
            bus.done       <= done_n;
            if (bus.wr_en && {1'b0, bus.wr_addr} < CAP) cbuf[bus.wr_addr] <= bus.wr_char;
        end
    end
endmodule

// File: tb/tb_banner_scan_ctrl.sv
// Directed bench for banner_scan_ctrl (MAX_CHARS=16, COL_TICKS=4).
module tb_banner_scan_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    logic [4:0] sc [4] = '{5'b11101, 5'b10101, 5'b10101, 5'b10111};
    logic [4:0] hc [4] = '{5'b11111, 5'b00100, 5'b00100, 5'b11111};

    banner_scan_ctrl_if #(.MAX_CHARS(16)) bus ();

    banner_scan_ctrl #(.MAX_CHARS(16), .COL_TICKS(4), .CHAR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [4:0] ch);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_char = ch;
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic kick(input logic [4:0] n);
        bus.msg_len = n; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        logic [4:0] e, orl;
        int nb, ns, k;
        bus.start = 1'b1; bus.stop = 1'b0; bus.loop_en = 1'b0; bus.msg_len = 5'd1;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_char = '0;

        // reset held with start asserted
        step(); step();
        chk("rst_lines", 32'(bus.lines), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_strobe", 32'(bus.col_strobe), 0);
        rst_n = 1'b1; bus.start = 1'b0;
        step();
        chk("post_rst_busy", 32'(bus.busy), 0);

        // blank buffer, msg_len above capacity clamps to 16 chars
        kick(5'd20);
        orl = '0; nb = 0;
        for (int c = 0; c < 320; c++) begin
            orl |= bus.lines;
            nb += int'(bus.busy);
            step();
        end
        chk("clamp_lines_blank", 32'(orl), 0);
        chk("clamp_busy_cycles", 32'(nb), 320);
        chk("clamp_done", 32'(bus.done), 1);
        chk("clamp_idle", 32'(bus.busy), 0);

        // single S, one shot
        wr(4'd0, 5'd19);
        kick(5'd1);
        for (int c = 0; c < 20; c++) begin
            e = (c < 16) ? sc[c/4] : 5'd0;
            chk($sformatf("s_lines_c%0d", c), 32'(bus.lines), 32'(e));
            chk($sformatf("s_strobe_c%0d", c), 32'(bus.col_strobe), 32'(c % 4 == 0));
            chk($sformatf("s_busy_c%0d", c), 32'(bus.busy), 1);
            chk($sformatf("s_done_c%0d", c), 32'(bus.done), 0);
            step();
        end
        chk("s_done", 32'(bus.done), 1);
        chk("s_busy_end", 32'(bus.busy), 0);
        chk("s_lines_end", 32'(bus.lines), 0);
        step();
        chk("s_done_pulse", 32'(bus.done), 0);

        // "SH" looping; third frame drops loop_en and shortens msg_len (ignored)
        wr(4'd1, 5'd8);
        bus.loop_en = 1'b1;
        kick(5'd2);
        ns = 0;
        for (int c = 0; c < 120; c++) begin
            if (c == 80) begin bus.loop_en = 1'b0; bus.msg_len = 5'd1; end
            k = c % 20;
            e = (k >= 16) ? 5'd0 : (((c % 40) >= 20) ? hc[k/4] : sc[k/4]);
            chk($sformatf("sh_lines_c%0d", c), 32'(bus.lines), 32'(e));
            chk($sformatf("sh_busy_c%0d", c), 32'(bus.busy), 1);
            ns += int'(bus.col_strobe);
            step();
        end
        chk("sh_strobes", 32'(ns), 30);
        chk("sh_done", 32'(bus.done), 1);
        chk("sh_idle", 32'(bus.busy), 0);

        // stop at scan cycle 7, then restart from col0
        kick(5'd1);
        for (int c = 0; c < 7; c++) step();
        chk("stop_pre_lines", 32'(bus.lines), 32'(sc[1]));
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        chk("stop_lines", 32'(bus.lines), 0);
        chk("stop_busy", 32'(bus.busy), 0);
        chk("stop_done", 32'(bus.done), 0);
        step();
        chk("stop_no_done", 32'(bus.done), 0);
        kick(5'd1);
        chk("restart_lines", 32'(bus.lines), 32'(sc[0]));
        chk("restart_strobe", 32'(bus.col_strobe), 1);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;

        // ignored starts
        kick(5'd0);
        chk("len0_busy", 32'(bus.busy), 0);
        bus.stop = 1'b1;
        kick(5'd1);
        bus.stop = 1'b0;
        chk("startstop_busy", 32'(bus.busy), 0);
        kick(5'd1);
        for (int c = 0; c < 5; c++) step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("busy_start_lines", 32'(bus.lines), 32'(sc[1]));
        chk("busy_start_strobe", 32'(bus.col_strobe), 0);

        // write to the shown char, visible one cycle after the buffer updates
        wr(4'd0, 5'd8);
        chk("wr_lag_lines", 32'(bus.lines), 32'(sc[1]));
        step();
        chk("wr_vis_lines", 32'(bus.lines), 32'(hc[2]));

        // reset mid-scan clears outputs and buffer
        rst_n = 1'b0;
        step();
        chk("midrst_lines", 32'(bus.lines), 0);
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_strobe", 32'(bus.col_strobe), 0);
        rst_n = 1'b1;
        kick(5'd1);
        chk("midrst_buf_blank", 32'(bus.lines), 0);
        chk("midrst_scan_busy", 32'(bus.busy), 1);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;

        // code 30 renders blank
        wr(4'd0, 5'd30);
        kick(5'd1);
        orl = '0;
        for (int c = 0; c < 20; c++) begin
            orl |= bus.lines;
            step();
        end
        chk("code30_blank", 32'(orl), 0);
        chk("code30_done", 32'(bus.done), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
